// File: rtl/fifo_sync_ext_pkg.sv
// Shared types for the extended synchronous FIFO.
package fifo_sync_ext_pkg;

  typedef enum logic {
    FIFO_MODE_STD  = 1'b0,
    FIFO_MODE_FWFT = 1'b1
  } fifo_mode_t;

endpackage

// File: rtl/fifo_sync_ext_if.sv
// Handshake, threshold and status bundle of fifo_sync_ext.
// Error ports exist only when FIFO_SYNC_EXT_ERR_EN is defined.
interface fifo_sync_ext_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] wdata;
  logic              wen;
  logic              full;
  logic              afull;
  logic [ADDR_W:0]   afull_thr;
  logic [DATA_W-1:0] rdata;
  logic              ren;
  logic              rvalid;
  logic              empty;
  logic              aempty;
  logic [ADDR_W:0]   aempty_thr;
  logic [ADDR_W:0]   load;
`ifdef FIFO_SYNC_EXT_ERR_EN
  logic              ovf;
  logic              udf;
  logic              err_clr;

  modport master (
    output wdata, wen, afull_thr, ren, aempty_thr, err_clr,
    input  full, afull, rdata, rvalid, empty, aempty, load, ovf, udf
  );
  modport slave (
    input  wdata, wen, afull_thr, ren, aempty_thr, err_clr,
    output full, afull, rdata, rvalid, empty, aempty, load, ovf, udf
  );
`else
  modport master (
    output wdata, wen, afull_thr, ren, aempty_thr,
    input  full, afull, rdata, rvalid, empty, aempty, load
  );
  modport slave (
    input  wdata, wen, afull_thr, ren, aempty_thr,
    output full, afull, rdata, rvalid, empty, aempty, load
  );
`endif
endinterface

// File: rtl/dpram.sv
// Simple dual-port RAM: one write port, one registered read port that holds
// its output while the read enable is low.
module dpram #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DATA_W    = 8,
  parameter string       INIT_FILE = ""
) (
  input  logic              i_wr_clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_clk,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);
  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rd_data;

  // Preloading is done by the vendor memory-init flow, not by this RTL.
  if (INIT_FILE != "") begin : g_init_by_flow
  end

  always_ff @(posedge i_wr_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge i_rd_clk) begin
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;
endmodule

// File: rtl/fifo_sync_ext.sv
// Single-clock FIFO with STD / FWFT read modes and runtime almost-full/empty
// thresholds. Define FIFO_SYNC_EXT_ERR_EN for sticky ovf/udf flags.
module fifo_sync_ext
  import fifo_sync_ext_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned WORDS_TOTAL = 2**ADDR_W,
  parameter fifo_mode_t  MODE        = FIFO_MODE_STD
) (
  input logic            clk,
  input logic            rst,
  fifo_sync_ext_if.slave bus
);
  localparam logic [ADDR_W:0] LoadMax = (ADDR_W+1)'(WORDS_TOTAL);

  logic [ADDR_W-1:0] r_waddr;
  logic [ADDR_W-1:0] r_raddr;
  logic [ADDR_W:0]   r_load;
  logic              r_rvalid;
  logic              w_full;
  logic              w_empty;
  logic              w_wr;
  logic              w_ram_rd;
  logic              w_pop;
  logic              w_bad_rd;
  logic [DATA_W-1:0] w_rdata;

  assign w_full  = (r_load == LoadMax);
  assign w_empty = (r_load == '0);
  assign w_wr    = bus.wen && !w_full;

  if (MODE == FIFO_MODE_FWFT) begin : g_fwft
    logic [ADDR_W:0] r_ram_cnt;

    // Prefetch whenever the output slot is free or being vacated this cycle.
    assign w_ram_rd = (r_ram_cnt != '0) && (!r_rvalid || bus.ren);
    assign w_pop    = bus.ren && r_rvalid;
    assign w_bad_rd = bus.ren && !r_rvalid;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_ram_cnt <= '0;
        r_rvalid  <= 1'b0;
      end else begin
        r_ram_cnt <= r_ram_cnt + {{ADDR_W{1'b0}}, w_wr} - {{ADDR_W{1'b0}}, w_ram_rd};
        r_rvalid  <= w_ram_rd || (r_rvalid && !bus.ren);
      end
    end
  end else begin : g_std
    assign w_ram_rd = bus.ren && !w_empty;
    assign w_pop    = w_ram_rd;
    assign w_bad_rd = bus.ren && w_empty;

    always_ff @(posedge clk) begin
      if (rst) r_rvalid <= 1'b0;
      else     r_rvalid <= w_ram_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_waddr <= '0;
      r_raddr <= '0;
      r_load  <= '0;
    end else begin
      if (w_wr)     r_waddr <= r_waddr + ADDR_W'(1);
      if (w_ram_rd) r_raddr <= r_raddr + ADDR_W'(1);
      if (w_wr && !w_pop)      r_load <= r_load + (ADDR_W+1)'(1);
      else if (!w_wr && w_pop) r_load <= r_load - (ADDR_W+1)'(1);
    end
  end

  dpram #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .INIT_FILE("")
  ) dpram (
    .i_wr_clk (clk),
    .i_wr_en  (w_wr),
    .i_wr_addr(r_waddr),
    .i_wr_data(bus.wdata),
    .i_rd_clk (clk),
    .i_rd_en  (w_ram_rd),
    .i_rd_addr(r_raddr),
    .o_rd_data(w_rdata)
  );

  assign bus.rdata  = w_rdata;
  assign bus.rvalid = r_rvalid;
  assign bus.load   = r_load;
  assign bus.full   = w_full;
  assign bus.empty  = w_empty;
  assign bus.afull  = (r_load >= bus.afull_thr);
  assign bus.aempty = (r_load <= bus.aempty_thr);

`ifdef FIFO_SYNC_EXT_ERR_EN
  logic r_ovf;
  logic r_udf;

  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (bus.wen && w_full) r_ovf <= 1'b1;
      else if (bus.err_clr)  r_ovf <= 1'b0;
      if (w_bad_rd)          r_udf <= 1'b1;
      else if (bus.err_clr)  r_udf <= 1'b0;
    end
  end

  assign bus.ovf = r_ovf;
  assign bus.udf = r_udf;
`else
  logic w_unused_bad_rd;
  assign w_unused_bad_rd = w_bad_rd;
`endif
endmodule

// File: tb/tb_fifo_sync_ext.sv
// Directed bench for fifo_sync_ext: a small STD instance (5 words, 3-bit
// addresses) and a default-size FWFT instance, each checked against a queue.
module tb_fifo_sync_ext;
  import fifo_sync_ext_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_sync_ext_if #(.ADDR_W(3),  .DATA_W(8)) s_if ();
  fifo_sync_ext_if #(.ADDR_W(10), .DATA_W(8)) f_if ();

  fifo_sync_ext #(
    .ADDR_W(3), .DATA_W(8), .WORDS_TOTAL(5), .MODE(FIFO_MODE_STD)
  ) u_std (
    .clk(clk), .rst(rst), .bus(s_if)
  );

  fifo_sync_ext #(
    .ADDR_W(10), .DATA_W(8), .WORDS_TOTAL(1024), .MODE(FIFO_MODE_FWFT)
  ) u_fwft (
    .clk(clk), .rst(rst), .bus(f_if)
  );

  int n_chk = 0;
  int n_err = 0;

  // STD model state
  logic [7:0] q_s[$];
  int         m_s_load = 0;
  bit         m_s_rv = 0;
  logic [7:0] m_s_rd = '0;
  bit         m_s_ovf = 0;
  bit         m_s_udf = 0;
  // FWFT model state: words still in RAM plus the presented word
  logic [7:0] q_f[$];
  bit         m_f_rv = 0;
  logic [7:0] m_f_word = '0;
  bit         m_f_ovf = 0;
  bit         m_f_udf = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_std();
    check("s_load", 32'(s_if.load), m_s_load);
    check("s_empty", 32'(s_if.empty), 32'(m_s_load == 0));
    check("s_full", 32'(s_if.full), 32'(m_s_load == 5));
    check("s_afull", 32'(s_if.afull), 32'(m_s_load >= 4));
    check("s_aempty", 32'(s_if.aempty), 32'(m_s_load <= 1));
    check("s_rvalid", 32'(s_if.rvalid), 32'(m_s_rv));
    if (m_s_rv) check("s_rdata", 32'(s_if.rdata), 32'(m_s_rd));
`ifdef FIFO_SYNC_EXT_ERR_EN
    check("s_ovf", 32'(s_if.ovf), 32'(m_s_ovf));
    check("s_udf", 32'(s_if.udf), 32'(m_s_udf));
`endif
  endtask

  task automatic check_fwft();
    int ld;
    ld = q_f.size() + int'(m_f_rv);
    check("f_load", 32'(f_if.load), ld);
    check("f_empty", 32'(f_if.empty), 32'(ld == 0));
    check("f_full", 32'(f_if.full), 32'(ld == 1024));
    check("f_afull", 32'(f_if.afull), 32'(1));
    check("f_aempty", 32'(f_if.aempty), 32'(ld <= 2));
    check("f_rvalid", 32'(f_if.rvalid), 32'(m_f_rv));
    if (m_f_rv) check("f_rdata", 32'(f_if.rdata), 32'(m_f_word));
`ifdef FIFO_SYNC_EXT_ERR_EN
    check("f_ovf", 32'(f_if.ovf), 32'(m_f_ovf));
    check("f_udf", 32'(f_if.udf), 32'(m_f_udf));
`endif
  endtask

  task automatic std_step(input bit w, input logic [7:0] d, input bit r, input bit clr);
    bit wr, rd;
    wr = w && (m_s_load != 5);
    rd = r && (m_s_load != 0);
    s_if.wen   = w;
    s_if.wdata = d;
    s_if.ren   = r;
`ifdef FIFO_SYNC_EXT_ERR_EN
    s_if.err_clr = clr;
`endif
    @(posedge clk);
    if (w && !wr) m_s_ovf = 1'b1;
    else if (clr) m_s_ovf = 1'b0;
    if (r && !rd) m_s_udf = 1'b1;
    else if (clr) m_s_udf = 1'b0;
    m_s_rv = rd;
    if (rd) m_s_rd = q_s.pop_front();
    if (wr) q_s.push_back(d);
    m_s_load = m_s_load + int'(wr) - int'(rd);
    #1;
    s_if.wen = 1'b0;
    s_if.ren = 1'b0;
`ifdef FIFO_SYNC_EXT_ERR_EN
    s_if.err_clr = 1'b0;
`endif
    check_std();
  endtask

  task automatic fwft_step(input bit w, input logic [7:0] d, input bit r, input bit clr);
    bit wr, ram_rd;
    wr     = w && ((q_f.size() + int'(m_f_rv)) != 1024);
    ram_rd = (q_f.size() != 0) && (!m_f_rv || r);
    f_if.wen   = w;
    f_if.wdata = d;
    f_if.ren   = r;
`ifdef FIFO_SYNC_EXT_ERR_EN
    f_if.err_clr = clr;
`endif
    @(posedge clk);
    if (w && !wr)         m_f_ovf = 1'b1;
    else if (clr)         m_f_ovf = 1'b0;
    if (r && !m_f_rv)     m_f_udf = 1'b1;
    else if (clr)         m_f_udf = 1'b0;
    m_f_rv = ram_rd || (m_f_rv && !r);
    if (ram_rd) m_f_word = q_f.pop_front();
    if (wr) q_f.push_back(d);
    #1;
    f_if.wen = 1'b0;
    f_if.ren = 1'b0;
`ifdef FIFO_SYNC_EXT_ERR_EN
    f_if.err_clr = 1'b0;
`endif
    check_fwft();
  endtask

  initial begin
    s_if.wen = 1'b0; s_if.ren = 1'b0; s_if.wdata = '0;
    s_if.afull_thr = 4'd4; s_if.aempty_thr = 4'd1;
    f_if.wen = 1'b0; f_if.ren = 1'b0; f_if.wdata = '0;
    f_if.afull_thr = 11'd0; f_if.aempty_thr = 11'd2;
`ifdef FIFO_SYNC_EXT_ERR_EN
    s_if.err_clr = 1'b0;
    f_if.err_clr = 1'b0;
`endif
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_std();
    check_fwft();
    rst = 1'b0;

    // STD: three words in, three out, one cycle read latency
    std_step(1, 8'h11, 0, 0);
    std_step(1, 8'h22, 0, 0);
    std_step(1, 8'h33, 0, 0);
    check("s_load3", 32'(s_if.load), 32'd3);
    std_step(0, 8'h00, 1, 0);
    check("s_first", 32'(s_if.rdata), 32'h11);
    std_step(0, 8'h00, 1, 0);
    std_step(0, 8'h00, 1, 0);
    check("s_third", 32'(s_if.rdata), 32'h33);
    std_step(0, 8'h00, 0, 0);

    // Fill past capacity, then write+read while full, then drain
    for (int i = 0; i < 6; i++) std_step(1, 8'h40 + 8'(i), 0, 0);
    check("s_full5", 32'(s_if.full), 32'd1);
    std_step(1, 8'hEE, 1, 0);
    for (int i = 0; i < 4; i++) std_step(0, 8'h00, 1, 0);
    std_step(0, 8'h00, 0, 1);

    // Thresholds while filling 0 -> 4, then wrap with load held at 2
    for (int i = 0; i < 4; i++) std_step(1, 8'h60 + 8'(i), 0, 0);
    check("s_afull4", 32'(s_if.afull), 32'd1);
    std_step(0, 8'h00, 1, 0);
    std_step(0, 8'h00, 1, 0);
    for (int i = 0; i < 20; i++) std_step(1, 8'h80 + 8'(i), 1, 0);
    check("s_wrap_load", 32'(s_if.load), 32'd2);
    std_step(0, 8'h00, 1, 0);
    std_step(0, 8'h00, 1, 0);

    // Illegal read on empty
    std_step(0, 8'h00, 1, 0);
    std_step(0, 8'h00, 0, 0);
    std_step(0, 8'h00, 0, 1);

    // FWFT: single word latency and pop
    fwft_step(1, 8'hA5, 0, 0);
    check("f_lat_n1", 32'(f_if.rvalid), 32'd0);
    fwft_step(0, 8'h00, 0, 0);
    check("f_lat_n2", 32'(f_if.rvalid), 32'd1);
    check("f_word_a5", 32'(f_if.rdata), 32'hA5);
    fwft_step(0, 8'h00, 1, 0);
    check("f_pop_load", 32'(f_if.load), 32'd0);
    fwft_step(0, 8'h00, 1, 0);
    fwft_step(0, 8'h00, 0, 1);

    // FWFT: burst in, back-to-back pops with concurrent writes, drain
    for (int i = 0; i < 4; i++) fwft_step(1, 8'hC0 + 8'(i), 0, 0);
    for (int i = 0; i < 10; i++) fwft_step(1, 8'hD0 + 8'(i), 1, 0);
    for (int i = 0; i < 6; i++) fwft_step(0, 8'h00, 1, 0);
    fwft_step(0, 8'h00, 0, 0);

    // Reset mid-operation discards contents
    std_step(1, 8'h01, 0, 0);
    std_step(1, 8'h02, 0, 0);
    fwft_step(1, 8'h03, 0, 0);
    fwft_step(1, 8'h04, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q_s.delete(); m_s_load = 0; m_s_rv = 0; m_s_ovf = 0; m_s_udf = 0;
    q_f.delete(); m_f_rv = 0; m_f_ovf = 0; m_f_udf = 0;
    check_std();
    check_fwft();
    std_step(0, 8'h00, 0, 0);
    fwft_step(0, 8'h00, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
